matrix_scan_driver: RTL and testbench

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_scan_driver.sv | 153 +++++++++++++++
 tb/tb_matrix_scan_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - row-scanned N x N red/green dot-matrix driver
//
// Purpose: time-multiplexes an N x N bi-colour dot matrix one row at a time
// and draws one of four fixed patterns (LOCKED frame, OPENED fill, ERROR
// cross, BLANK). The displayed pattern only changes on frame boundaries.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   mode[1:0]    in   00 LOCKED, 01 OPENED, 10 ERROR, 11 BLANK
//   row[N-1:0]   out  row select, active-low, at most one bit low
//   col_r[N-1:0] out  red column drive, active-high, bit c = column c
//   col_g[N-1:0] out  green column drive, active-high, bit c = column c
//
// Build option: define MATRIX_BLINK_EN to blink the ERROR pattern with a
// half-period of BLINK_FRAMES frames; otherwise ERROR is shown steadily.
module matrix_scan_driver #(
  parameter int N            = 8,
  parameter int SCAN_DIV     = 1250,
  parameter int BLINK_FRAMES = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  output logic [N-1:0] row,
  output logic [N-1:0] col_r,
  output logic [N-1:0] col_g
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    MODE_LOCKED = 2'b00,
    MODE_OPENED = 2'b01,
    MODE_ERROR  = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  logic [PW-1:0] p_q, p_d;
  logic [RW-1:0] r_q, r_d;
  mode_e         mode_q, mode_d;
  logic [N-1:0]  row_q, row_d;
  logic [N-1:0]  col_r_q, col_r_d;
  logic [N-1:0]  col_g_q, col_g_d;

  logic          last_p;
  logic          last_r;
  logic          frame_end;
  logic [N-1:0]  row_bit;
  logic [N-1:0]  mirror_bit;
  logic          show_error;

`ifdef MATRIX_BLINK_EN
  localparam int FW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  logic [FW-1:0] f_q, f_d;
`endif

  assign last_p     = (p_q == PW'(SCAN_DIV - 1));
  assign last_r     = (r_q == RW'(N - 1));
  assign frame_end  = last_p && last_r;
  assign row_bit    = N'(1) << r_q;
  assign mirror_bit = N'(1) << (RW'(N - 1) - r_q);

  always_comb begin
    p_d    = last_p ? '0 : p_q + 1'b1;
    r_d    = r_q;
    mode_d = mode_q;
    if (last_p) begin
      r_d = last_r ? '0 : r_q + 1'b1;
    end
    // Mode is latched only at the frame wrap so a frame is never torn.
    if (frame_end) begin
      mode_d = mode_e'(mode);
    end
  end

`ifdef MATRIX_BLINK_EN
  // Frame counter restarts on a mode change so a fresh ERROR begins lit.
  always_comb begin
    f_d = f_q;
    if (frame_end) begin
      if (mode_e'(mode) != mode_q) begin
        f_d = '0;
      end else if (f_q == FW'(2 * BLINK_FRAMES - 1)) begin
        f_d = '0;
      end else begin
        f_d = f_q + 1'b1;
      end
    end
  end
  assign show_error = (f_q < FW'(BLINK_FRAMES));
`else
  assign show_error = 1'b1;
`endif

  // p == 0 is the anti-ghosting gap: everything off for one cycle per slot.
  always_comb begin
    row_d   = '1;
    col_r_d = '0;
    col_g_d = '0;
    if (p_q != '0) begin
      case (mode_q)
        MODE_LOCKED: begin
          row_d   = ~row_bit;
          col_r_d = (r_q == '0 || last_r) ? '1 : {1'b1, {(N-2){1'b0}}, 1'b1};
        end
        MODE_OPENED: begin
          row_d   = ~row_bit;
          col_g_d = '1;
        end
        MODE_ERROR: begin
          if (show_error) begin
            row_d   = ~row_bit;
            col_r_d = row_bit | mirror_bit;
          end
        end
        default: begin
          row_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      r_q     <= '0;
      mode_q  <= MODE_BLANK;
      row_q   <= '1;
      col_r_q <= '0;
      col_g_q <= '0;
`ifdef MATRIX_BLINK_EN
      f_q     <= '0;
`endif
    end else begin
      p_q     <= p_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_r_q <= col_r_d;
      col_g_q <= col_g_d;
`ifdef MATRIX_BLINK_EN
      f_q     <= f_d;
`endif
    end
  end

  assign row   = row_q;
  assign col_r = col_r_q;
  assign col_g = col_g_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - self-checking bench for matrix_scan_driver
module tb_matrix_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = N * SD;

  logic         clk;
  logic         rst;
  logic [1:0]   mode;
  logic [N-1:0] row;
  logic [N-1:0] col_r;
  logic [N-1:0] col_g;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles since reset release, displayed mode, frame count.
  int s    = 0;
  int disp = 3;
  int f    = 0;

  matrix_scan_driver #(
    .N(N),
    .SCAN_DIV(SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .row(row),
    .col_r(col_r),
    .col_g(col_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, sample 1 ns after the edge, compare, advance model.
  task automatic tick(input logic rst_v, input logic [1:0] m);
    int p, r;
    logic [N-1:0] e_row, e_r, e_g;
    logic dark;
    rst  = rst_v;
    mode = m;
    @(posedge clk);
    #1;
    e_row = '1;
    e_r   = '0;
    e_g   = '0;
    if (rst_v) begin
      s = 0; disp = 3; f = 0;
    end else begin
      p = s % SD;
      r = (s / SD) % N;
`ifdef MATRIX_BLINK_EN
      dark = (f >= BF);
`else
      dark = 1'b0;
`endif
      if (p != 0) begin
        if (disp == 0) begin
          e_row = ~(N'(1) << r);
          e_r = (r == 0 || r == N - 1) ? '1 : N'((1 << (N - 1)) | 1);
        end else if (disp == 1) begin
          e_row = ~(N'(1) << r);
          e_g = '1;
        end else if (disp == 2 && !dark) begin
          e_row = ~(N'(1) << r);
          e_r = N'((1 << r) | (1 << (N - 1 - r)));
        end
      end
      if (s % FRAME == FRAME - 1) begin
        f = (int'(m) != disp) ? 0 : (f + 1) % (2 * BF);
        disp = int'(m);
      end
      s++;
    end
    chk("row", 32'(row), 32'(e_row));
    chk("col_r", 32'(col_r), 32'(e_r));
    chk("col_g", 32'(col_g), 32'(e_g));
    chk("row_onehot", 32'($countones(~row) <= 1), 32'd1);
    chk("no_overlap", 32'(col_r & col_g), 32'd0);
  endtask

  task automatic run(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) tick(1'b0, m);
  endtask

  task automatic align(input int pos, input logic [1:0] m);
    while (s % FRAME != pos) tick(1'b0, m);
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'b00;

    // Reset for 3 cycles, LOCKED held; first frame dark, then LOCKED.
    for (int i = 0; i < 3; i++) tick(1'b1, 2'b00);
    chk("reset_row", 32'(row), 32'hF);
    chk("reset_cols", 32'({col_r, col_g}), 32'h0);
    run(16, 2'b00);
    chk("f1_blank_row", 32'(row), 32'hF);
    run(1, 2'b00);
    chk("f2_gap_row", 32'(row), 32'hF);
    run(1, 2'b00);
    chk("f2_row0_row", 32'(row), 32'hE);
    chk("f2_row0_col_r", 32'(col_r), 32'hF);
    run(3, 2'b00);
    chk("f2_row1_gap", 32'(row), 32'hF);
    run(1, 2'b00);
    chk("f2_row1_row", 32'(row), 32'hD);
    chk("f2_row1_col_r", 32'(col_r), 32'h9);

    // Switch LOCKED -> OPENED at cycle 5 of a frame.
    align(0, 2'b00);
    run(5, 2'b00);
    run(11, 2'b01);
    chk("tear_still_locked", 32'(col_r), 32'hF);
    run(2, 2'b01);
    chk("opened_row0_row", 32'(row), 32'hE);
    chk("opened_row0_col_g", 32'(col_g), 32'hF);
    run(2 * FRAME, 2'b01);

    // ERROR for several frames (blinking or steady depending on build).
    run(6 * FRAME, 2'b10);

    // Reset in the middle of the row-2 slot, then a forced blank frame.
    align(9, 2'b10);
    tick(1'b1, 2'b01);
    chk("midrst_row", 32'(row), 32'hF);
    chk("midrst_cols", 32'({col_r, col_g}), 32'h0);
    run(2 * FRAME, 2'b01);

    // Randomized modes with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      tick(($urandom_range(0, 149) == 0), mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
